// File: rtl/stick_pkg.sv
`default_nettype none
// ============================================================================
// stick_pkg : shared header layout, state encoding for frame_packetizer_mux
// Config macro: STICK_FMUX_TSTAMP_EN (adds a timestamp header word)
// Rev 1.0
// ============================================================================
package stick_pkg;

    localparam logic [7:0] HDR_MAGIC = 8'hA5;

`ifdef STICK_FMUX_TSTAMP_EN
    localparam int HDR_WORDS = 3;
`else
    localparam int HDR_WORDS = 2;
`endif

    localparam int HDR_MAGIC_LSB = 24;
    localparam int HDR_CH_LSB    = 20;
    localparam int HDR_SEQ_LSB   = 0;
    localparam int HDR_LEN_LSB   = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HDR   = 2'd1,
        PAY   = 2'd2,
        DRAIN = 2'd3
    } fmux_state_t;

endpackage
`default_nettype wire

// File: rtl/frame_packetizer_mux_rr_arbiter.sv
`default_nettype none
// ============================================================================
// rr_arbiter : combinational round-robin pick, search starts just above i_ptr
// Rev 1.0
// ============================================================================
module rr_arbiter #(
    parameter int N_CH = 4
) (
    input  logic [N_CH-1:0] i_req,
    input  logic [3:0]      i_ptr,
    output logic [N_CH-1:0] o_gnt,
    output logic [3:0]      o_idx,
    output logic            o_any
);

    logic       w_hi_any;
    logic [3:0] w_hi_idx;
    logic       w_lo_any;
    logic [3:0] w_lo_idx;

    // Descending scan leaves the lowest requester above and at/below the pointer.
    always_comb begin
        w_hi_any = 1'b0;
        w_hi_idx = '0;
        w_lo_any = 1'b0;
        w_lo_idx = '0;
        for (int c = N_CH - 1; c >= 0; c--) begin
            if (i_req[c] && (4'(c) > i_ptr)) begin
                w_hi_any = 1'b1;
                w_hi_idx = 4'(c);
            end
            if (i_req[c] && (4'(c) <= i_ptr)) begin
                w_lo_any = 1'b1;
                w_lo_idx = 4'(c);
            end
        end
    end

    always_comb begin
        o_any = w_hi_any | w_lo_any;
        o_idx = w_hi_any ? w_hi_idx : w_lo_idx;
        o_gnt = '0;
        for (int c = 0; c < N_CH; c++) begin
            o_gnt[c] = o_any && (o_idx == 4'(c));
        end
    end

endmodule
`default_nettype wire

// File: rtl/frame_packetizer_mux.sv
`default_nettype none
// ============================================================================
// frame_packetizer_mux : round-robin N_CH frame collector emitting tagged packets
// Config macro: STICK_FMUX_TSTAMP_EN (timestamp header word)
// Rev 1.0
// ============================================================================
module frame_packetizer_mux
    import stick_pkg::*;
#(
    parameter int         N_CH      = 4,
    parameter int         DW        = 32,
    parameter int         MAX_WORDS = 4096,
    parameter int         SZW       = 16,
    parameter logic [7:0] MAGIC     = HDR_MAGIC
) (
    input  logic                sys_clk,
    input  logic                rst,
    input  logic [N_CH-1:0]     i_frame_ready,
    input  logic [N_CH*SZW-1:0] i_frame_size,
    input  logic [N_CH*DW-1:0]  i_in_data,
    input  logic [N_CH-1:0]     i_in_vld,
    output logic [N_CH-1:0]     o_in_rdy,
    output logic [DW-1:0]       o_tx_data,
    output logic                o_tx_vld,
    output logic                o_tx_sop,
    output logic                o_tx_eop,
    input  logic                i_tx_rdy,
    output logic [SZW-1:0]      o_pkt_len,
    output logic [15:0]         o_drop_cnt,
    output logic                o_err_oversize
);

    localparam logic [SZW-1:0] C_MAXW     = SZW'(MAX_WORDS);
    localparam logic [SZW-1:0] C_ONE      = SZW'(1);
    localparam logic [SZW-1:0] C_HDR_LAST = SZW'(HDR_WORDS - 1);

    fmux_state_t               state_q;
    logic [N_CH-1:0]           pend_q;
    logic [N_CH-1:0][SZW-1:0]  size_q;
    logic [3:0]                rr_q;
    logic [3:0]                g_q;
    logic [15:0]               seq_q;
    logic [15:0]               hseq_q;
    logic [15:0]               drop_q;
    logic [SZW-1:0]            fwd_q;
    logic [SZW-1:0]            rem_q;
    logic [SZW-1:0]            cnt_q;
    logic [SZW-1:0]            len_q;
    logic                      err_q;

    logic [N_CH-1:0]           w_gnt;
    logic [3:0]                w_gidx;
    logic                      w_any;
    logic                      w_grant;
    logic [SZW-1:0]            w_size_g;
    logic [SZW-1:0]            w_fwd_g;
    logic [4:0]                w_ndrop;
    logic [16:0]               w_drop_sum;
    logic                      w_pay_vld;
    logic [DW-1:0]             w_pay_data;
    logic [DW-1:0]             w_hdr_word;
    logic                      w_xfer;

    rr_arbiter #(.N_CH(N_CH)) u_arb (
        .i_req (pend_q),
        .i_ptr (rr_q),
        .o_gnt (w_gnt),
        .o_idx (w_gidx),
        .o_any (w_any)
    );

    assign w_grant = (state_q == IDLE) && w_any;
    assign w_fwd_g = (w_size_g > C_MAXW) ? C_MAXW : w_size_g;
    assign w_xfer  = o_tx_vld & i_tx_rdy;

    always_comb begin
        w_size_g   = '0;
        w_pay_vld  = 1'b0;
        w_pay_data = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (w_gidx == 4'(c)) w_size_g = size_q[c];
            if (g_q == 4'(c)) begin
                w_pay_vld  = i_in_vld[c];
                w_pay_data = i_in_data[c*DW +: DW];
            end
        end
    end

    // A pulse on the channel being granted this cycle re-arms it instead of dropping.
    always_comb begin
        w_ndrop = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (i_frame_ready[c] && pend_q[c] && !(w_grant && w_gnt[c])) w_ndrop = w_ndrop + 5'd1;
        end
        w_drop_sum = {1'b0, drop_q} + {12'h0, w_ndrop};
    end

`ifdef STICK_FMUX_TSTAMP_EN
    logic [31:0] ts_free_q;
    logic [31:0] ts_q;

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            ts_free_q <= '0;
            ts_q      <= '0;
        end else begin
            ts_free_q <= ts_free_q + 32'd1;
            if (w_grant) ts_q <= ts_free_q;
        end
    end
`endif

    always_comb begin
        w_hdr_word = '0;
        case (cnt_q[1:0])
            2'd0: begin
                w_hdr_word[HDR_MAGIC_LSB +: 8] = MAGIC;
                w_hdr_word[HDR_CH_LSB +: 4]    = g_q;
                w_hdr_word[HDR_SEQ_LSB +: 16]  = hseq_q;
            end
            2'd1: w_hdr_word[HDR_LEN_LSB +: 16] = 16'(fwd_q);
`ifdef STICK_FMUX_TSTAMP_EN
            2'd2: w_hdr_word = DW'(ts_q);
`endif
            default: ;
        endcase
    end

    always_comb begin
        o_tx_vld  = 1'b0;
        o_tx_data = '0;
        o_tx_sop  = 1'b0;
        o_tx_eop  = 1'b0;
        o_in_rdy  = '0;
        case (state_q)
            HDR: begin
                o_tx_vld  = 1'b1;
                o_tx_data = w_hdr_word;
                o_tx_sop  = (cnt_q == '0);
                o_tx_eop  = (cnt_q == C_HDR_LAST) && (fwd_q == '0);
            end
            PAY: begin
                o_tx_vld  = w_pay_vld;
                o_tx_data = w_pay_data;
                o_tx_eop  = (cnt_q == fwd_q - C_ONE);
                for (int c = 0; c < N_CH; c++) o_in_rdy[c] = (g_q == 4'(c)) && i_tx_rdy;
            end
            DRAIN: begin
                for (int c = 0; c < N_CH; c++) o_in_rdy[c] = (g_q == 4'(c));
            end
            default: ;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q <= IDLE;
            pend_q  <= '0;
            size_q  <= '0;
            rr_q    <= '0;
            g_q     <= '0;
            seq_q   <= '0;
            hseq_q  <= '0;
            drop_q  <= '0;
            fwd_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                if (w_grant && w_gnt[c]) pend_q[c] <= 1'b0;
                if (i_frame_ready[c] && (!pend_q[c] || (w_grant && w_gnt[c]))) begin
                    pend_q[c] <= 1'b1;
                    size_q[c] <= i_frame_size[c*SZW +: SZW];
                end
            end
            drop_q <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];

            case (state_q)
                IDLE: begin
                    if (w_grant) begin
                        state_q <= HDR;
                        g_q     <= w_gidx;
                        rr_q    <= w_gidx;
                        hseq_q  <= seq_q;
                        seq_q   <= seq_q + 16'd1;
                        fwd_q   <= w_fwd_g;
                        rem_q   <= w_size_g - w_fwd_g;
                        len_q   <= SZW'((HDR_WORDS + int'(w_fwd_g)) * 4);
                        cnt_q   <= '0;
                        if (w_size_g > C_MAXW) err_q <= 1'b1;
                    end
                end
                HDR: begin
                    if (w_xfer) begin
                        if (cnt_q == C_HDR_LAST) begin
                            cnt_q   <= '0;
                            state_q <= (fwd_q == '0) ? IDLE : PAY;
                        end else begin
                            cnt_q <= cnt_q + C_ONE;
                        end
                    end
                end
                PAY: begin
                    if (w_xfer) begin
                        if (cnt_q == fwd_q - C_ONE) state_q <= (rem_q == '0) ? IDLE : DRAIN;
                        else                        cnt_q   <= cnt_q + C_ONE;
                    end
                end
                DRAIN: begin
                    if (w_pay_vld) begin
                        rem_q <= rem_q - C_ONE;
                        if (rem_q == C_ONE) state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_pkt_len      = len_q;
    assign o_drop_cnt     = drop_q;
    assign o_err_oversize = err_q;

endmodule
`default_nettype wire

// File: tb/tb_frame_packetizer_mux.sv
`default_nettype none
// ============================================================================
// tb_frame_packetizer_mux : vectors + random traffic against a packet-level model
// Rev 1.0
// ============================================================================
module tb_frame_packetizer_mux;

    localparam int N_CH = 4;
    localparam int DW   = 32;
    localparam int MAXW = 8;
    localparam int SZW  = 16;
    localparam int HW   = 2;

    logic                clk = 1'b0;
    logic                rst;
    logic [N_CH-1:0]     i_frame_ready;
    logic [N_CH*SZW-1:0] i_frame_size;
    logic [N_CH*DW-1:0]  i_in_data;
    logic [N_CH-1:0]     i_in_vld;
    logic [N_CH-1:0]     o_in_rdy;
    logic [DW-1:0]       o_tx_data;
    logic                o_tx_vld, o_tx_sop, o_tx_eop, i_tx_rdy;
    logic [SZW-1:0]      o_pkt_len;
    logic [15:0]         o_drop_cnt;
    logic                o_err_oversize;

    always #5 clk = ~clk;

    frame_packetizer_mux #(.N_CH(N_CH), .DW(DW), .MAX_WORDS(MAXW), .SZW(SZW)) dut (
        .sys_clk(clk), .rst(rst), .i_frame_ready(i_frame_ready), .i_frame_size(i_frame_size),
        .i_in_data(i_in_data), .i_in_vld(i_in_vld), .o_in_rdy(o_in_rdy), .o_tx_data(o_tx_data),
        .o_tx_vld(o_tx_vld), .o_tx_sop(o_tx_sop), .o_tx_eop(o_tx_eop), .i_tx_rdy(i_tx_rdy),
        .o_pkt_len(o_pkt_len), .o_drop_cnt(o_drop_cnt), .o_err_oversize(o_err_oversize)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Packet-level reference: pending set, last-served channel, global seq.
    bit [N_CH-1:0]  mpend;
    int             msize[N_CH];
    int             mrr, mseq, mdrop;
    bit             merr;
    int             cons[N_CH];
    int             src_cnt[N_CH];
    logic [31:0]    exp_q[$];
    logic [31:0]    hdr0_log[$];
    bit             in_pkt;
    int             nwords, done_cnt, last_nwords, last_len;
    logic [31:0]    last_hdr0, last_hdr1;
    bit [N_CH-1:0]  prev_mask, held_v;
    int             prev_size[N_CH];
    bit             prev_stall, prev_sop, prev_eop;
    logic [31:0]    prev_data;
    bit             rand_mode;

    task automatic start_packet();
        int g;
        int fwd;
        g = -1;
        for (int k = 1; k <= N_CH; k++) begin
            if (g < 0 && mpend[(mrr + k) % N_CH]) g = (mrr + k) % N_CH;
        end
        in_pkt = 1'b1;
        nwords = 0;
        if (g < 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_sop: got sop with data %h, required no packet", o_tx_data);
        end else begin
            mpend[g] = 1'b0;
            mrr = g;
            fwd = (msize[g] > MAXW) ? MAXW : msize[g];
            if (msize[g] > MAXW) merr = 1'b1;
            exp_q.push_back({8'hA5, 4'(g), 4'h0, 16'(mseq)});
            mseq = (mseq + 1) % 65536;
            exp_q.push_back({16'h0, 16'(fwd)});
            for (int k = 0; k < fwd; k++) exp_q.push_back({4'(g), 28'(cons[g] + k)});
            cons[g] += msize[g];
            last_len = (HW + fwd) * 4;
            chk("pkt_len", 32'(o_pkt_len), 32'(last_len));
        end
    endtask

    always @(negedge clk) begin
        for (int c = 0; c < N_CH; c++) begin
            if (i_in_vld[c] && o_in_rdy[c]) src_cnt[c]++;
            held_v[c] = i_in_vld[c] && !o_in_rdy[c];
        end
        if (rst) begin
            mpend = '0; mrr = 0; mseq = 0; mdrop = 0; merr = 1'b0;
            for (int c = 0; c < N_CH; c++) cons[c] = src_cnt[c];
            exp_q.delete();
            in_pkt = 1'b0; prev_stall = 1'b0; prev_mask = '0;
        end else begin
            if (prev_stall) begin
                chk("hold_vld", 32'(o_tx_vld), 32'd1);
                chk("hold_data", o_tx_data, prev_data);
                chk("hold_sop_eop", {30'h0, o_tx_sop, o_tx_eop}, {30'h0, prev_sop, prev_eop});
            end
            prev_stall = o_tx_vld && !i_tx_rdy;
            prev_data = o_tx_data; prev_sop = o_tx_sop; prev_eop = o_tx_eop;
            if (o_tx_vld && o_tx_sop && !in_pkt) start_packet();
            if (o_tx_vld && i_tx_rdy) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got %h, required no transfer", o_tx_data);
                end else begin
                    logic [31:0] e;
                    e = exp_q.pop_front();
                    chk("tx_data", o_tx_data, e);
                    chk("tx_sop", 32'(o_tx_sop), 32'(nwords == 0));
                    chk("tx_eop", 32'(o_tx_eop), 32'(exp_q.size() == 0));
                    if (nwords == 0) begin last_hdr0 = o_tx_data; hdr0_log.push_back(o_tx_data); end
                    if (nwords == 1) last_hdr1 = o_tx_data;
                    nwords++;
                    if (exp_q.size() == 0) begin
                        in_pkt = 1'b0;
                        last_nwords = nwords;
                        done_cnt++;
                    end
                end
            end
            // Pulses land one cycle late so a grant-cycle pulse re-arms the granted channel.
            for (int c = 0; c < N_CH; c++) begin
                if (prev_mask[c]) begin
                    if (mpend[c]) begin
                        if (mdrop < 65535) mdrop++;
                    end else begin
                        mpend[c] = 1'b1;
                        msize[c] = prev_size[c];
                    end
                end
                prev_size[c] = int'(i_frame_size[c*SZW +: SZW]);
            end
            prev_mask = i_frame_ready;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        i_frame_ready = '0;
        for (int c = 0; c < N_CH; c++) begin
            i_in_data[c*DW +: DW] = {4'(c), 28'(src_cnt[c])};
            i_in_vld[c] = held_v[c] ? 1'b1 : (rand_mode ? ($urandom_range(3) != 0) : 1'b1);
        end
        i_tx_rdy = rand_mode ? ($urandom_range(2) != 0) : 1'b1;
    endtask

    task automatic pulse(input int ch, input int sz);
        i_frame_ready[ch] = 1'b1;
        i_frame_size[ch*SZW +: SZW] = 16'(sz);
        step();
    endtask

    task automatic wait_done(input int target);
        int n;
        n = 0;
        while (done_cnt < target && n < 400) begin step(); n++; end
        if (done_cnt < target) begin
            checks++;
            errors++;
            $display("FAIL timeout: packets done %0d, required %0d", done_cnt, target);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_tx_vld"}, 32'(o_tx_vld), 32'd0);
        chk({tag, "_sop_eop"}, {30'h0, o_tx_sop, o_tx_eop}, 32'd0);
        chk({tag, "_in_rdy"}, 32'(o_in_rdy), 32'd0);
        chk({tag, "_tx_data"}, o_tx_data, 32'd0);
        chk({tag, "_pkt_len"}, 32'(o_pkt_len), 32'd0);
        chk({tag, "_drop"}, 32'(o_drop_cnt), 32'd0);
        chk({tag, "_err"}, 32'(o_err_oversize), 32'd0);
    endtask

    typedef struct {
        int          ch;
        int          size;
        logic [31:0] hdr0;
        logic [31:0] hdr1;
        int          nwords;
        int          len;
        bit          err;
    } vec_t;

    vec_t tbl[5];

    initial begin
        int base, d, n;
        logic [3:0] m;
        tbl[0] = '{2, 3,  32'hA520_0000, 32'h0000_0003, 5,  20, 1'b0};
        tbl[1] = '{0, 0,  32'hA500_0001, 32'h0000_0000, 2,  8,  1'b0};
        tbl[2] = '{3, 8,  32'hA530_0002, 32'h0000_0008, 10, 40, 1'b0};
        tbl[3] = '{1, 1,  32'hA510_0003, 32'h0000_0001, 3,  12, 1'b0};
        tbl[4] = '{1, 10, 32'hA510_0004, 32'h0000_0008, 10, 40, 1'b1};

        rst = 1'b1; i_frame_ready = '0; i_frame_size = '0; i_in_data = '0;
        i_in_vld = '0; i_tx_rdy = 1'b0; rand_mode = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        check_reset_outputs("reset");

        for (int i = 0; i < 5; i++) begin
            base = src_cnt[tbl[i].ch];
            d = done_cnt;
            pulse(tbl[i].ch, tbl[i].size);
            wait_done(d + 1);
            repeat (6) step();
            chk($sformatf("v%0d_hdr0", i), last_hdr0, tbl[i].hdr0);
            chk($sformatf("v%0d_hdr1", i), last_hdr1, tbl[i].hdr1);
            chk($sformatf("v%0d_nwords", i), 32'(last_nwords), 32'(tbl[i].nwords));
            chk($sformatf("v%0d_len", i), 32'(last_len), 32'(tbl[i].len));
            chk($sformatf("v%0d_err", i), 32'(o_err_oversize), 32'(tbl[i].err));
            chk($sformatf("v%0d_consumed", i), 32'(src_cnt[tbl[i].ch] - base), 32'(tbl[i].size));
        end

        // Simultaneous requests after reset: rr=0 so service order is 1,3,0.
        rst = 1'b1; step(); rst = 1'b0;
        hdr0_log.delete();
        d = done_cnt;
        i_frame_ready = 4'b1011;
        i_frame_size = {16'd1, 16'd0, 16'd2, 16'd1};
        step();
        wait_done(d + 3);
        chk("rr_first", hdr0_log[0], 32'hA510_0000);
        chk("rr_second", hdr0_log[1], 32'hA530_0001);
        chk("rr_third", hdr0_log[2], 32'hA500_0002);
        repeat (10) step();

        // Pulse on the granted channel in its grant cycle re-arms; a later one drops.
        d = done_cnt;
        pulse(1, 4);
        pulse(1, 2);
        chk("drop_after_regrant", 32'(o_drop_cnt), 32'd0);
        pulse(1, 3);
        step();
        chk("drop_after_pending", 32'(o_drop_cnt), 32'd1);
        wait_done(d + 2);
        chk("rearmed_size", last_hdr1, 32'h0000_0002);
        repeat (10) step();

        rand_mode = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(9) == 0) begin
                m = 4'($urandom_range(15));
                for (int c = 0; c < N_CH; c++) begin
                    i_frame_ready[c] = m[c];
                    i_frame_size[c*SZW +: SZW] = 16'($urandom_range(12));
                end
            end
            step();
        end
        n = 0;
        while ((in_pkt || mpend != '0) && n < 3000) begin step(); n++; end
        rand_mode = 1'b0;
        repeat (20) step();
        chk("rand_idle", {30'h0, in_pkt, 1'b0} | 32'(mpend != '0), 32'd0);
        chk("rand_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("rand_drop_cnt", 32'(o_drop_cnt), 32'(mdrop));
        chk("rand_err", 32'(o_err_oversize), 32'(merr));
        for (int c = 0; c < N_CH; c++) chk($sformatf("rand_consumed_ch%0d", c), 32'(src_cnt[c]), 32'(cons[c]));

        // Reset in the middle of a payload.
        pulse(0, 6);
        repeat (4) step();
        rst = 1'b1; step(); rst = 1'b0;
        check_reset_outputs("midpay_reset");
        d = done_cnt;
        pulse(2, 2);
        wait_done(d + 1);
        chk("post_reset_hdr0", last_hdr0, 32'hA520_0000);
        repeat (5) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
